// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message front-end.
// Imported by the padder and its word-padding helper.
package sha256_pkg;

    localparam int         BLK_W    = 512;
    localparam int         WORD_W   = 32;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic {
        FILL,
        EMIT
    } padder_state_e;

    // Element 15 is message word 0 so the packed vector puts word 0 on top
    typedef logic [15:0][WORD_W-1:0] blk_words_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaper: keeps the valid leading bytes, zeroes the rest and
// drops the 0x80 marker right after them; flags a full word (marker spills).
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [2:0]        nbytes,
    output logic [WORD_W-1:0] word,
    output logic              ovf
);

    // Byte-count driven mask and marker insertion
    always_comb begin
        word = data;
        ovf  = 1'b0;
        case (nbytes)
            3'd0:    word = {PAD_BYTE, 24'h0};
            3'd1:    word = {data[31:24], PAD_BYTE, 16'h0};
            3'd2:    word = {data[31:16], PAD_BYTE, 8'h0};
            3'd3:    word = {data[31:8], PAD_BYTE};
            default: ovf  = 1'b1;
        endcase
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit length.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [2:0]        in_bytes,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [BLK_W-1:0]  blk_data,
    output logic              blk_first,
    output logic              blk_last
);

    padder_state_e     state;
    blk_words_t        blk_q;
    blk_words_t        fill_blk;
    blk_words_t        extra_blk;
    logic [3:0]        widx;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  len_next;
    logic [63:0]       len_fill;
    logic [63:0]       len_cur;
    logic              first_flag;
    logic              pend_extra;
    logic              pend_80;
    logic [2:0]        b_eff;
    logic [WORD_W-1:0] pad_word;
    logic              pad_ovf;
    logic [4:0]        p_idx;

    // Byte counts above four behave as a full word
    assign b_eff    = in_bytes[2] ? 3'd4 : in_bytes;
    assign len_next = bit_cnt + LEN_W'({b_eff, 3'b000});
    assign len_fill = 64'(len_next);
    assign len_cur  = 64'(bit_cnt);
    assign p_idx    = {1'b0, widx} + {4'b0000, pad_ovf};

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_data  = blk_q;

    sha256_pad_word u_pad_word (
        .data   (in_data),
        .nbytes (b_eff),
        .word   (pad_word),
        .ovf    (pad_ovf)
    );

    // Block image after accepting the final word of a message
    always_comb begin
        fill_blk = blk_q;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) == {1'b0, widx})
                fill_blk[15-i] = pad_ovf ? in_data : pad_word;
            else if (5'(i) == p_idx)
                fill_blk[15-i] = {PAD_BYTE, 24'h0};
            else if (5'(i) > {1'b0, widx})
                fill_blk[15-i] = '0;
        end
        if (p_idx <= 5'd13) begin
            fill_blk[1] = len_fill[63:32];
            fill_blk[0] = len_fill[31:0];
        end
    end

    // Trailing block when the length did not fit behind the data
    always_comb begin
        extra_blk     = '0;
        extra_blk[15] = pend_80 ? {PAD_BYTE, 24'h0} : '0;
        extra_blk[1]  = len_cur[63:32];
        extra_blk[0]  = len_cur[31:0];
    end

    // Fill/emit sequencing with registered block outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            blk_q      <= '0;
            widx       <= '0;
            bit_cnt    <= '0;
            first_flag <= 1'b1;
            pend_extra <= 1'b0;
            pend_80    <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
        end else begin
            unique case (state)
                FILL: if (in_valid) begin
                    if (in_last) begin
                        blk_q      <= fill_blk;
                        bit_cnt    <= len_next;
                        blk_first  <= first_flag;
                        blk_last   <= (p_idx <= 5'd13);
                        pend_extra <= (p_idx >= 5'd14);
                        pend_80    <= p_idx[4];
                        state      <= EMIT;
                    end else begin
                        blk_q[4'd15 - widx] <= in_data;
                        bit_cnt <= bit_cnt + LEN_W'(32);
                        widx    <= widx + 4'd1;
                        if (widx == 4'd15) begin
                            blk_first <= first_flag;
                            blk_last  <= 1'b0;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: if (blk_ready) begin
                    first_flag <= 1'b0;
                    if (pend_extra) begin
                        blk_q      <= extra_blk;
                        blk_first  <= 1'b0;
                        blk_last   <= 1'b1;
                        pend_extra <= 1'b0;
                        pend_80    <= 1'b0;
                    end else begin
                        state <= FILL;
                        widx  <= '0;
                        if (blk_last) begin
                            bit_cnt    <= '0;
                            first_flag <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder: byte-level FIPS 180-4 padding model
// feeding an expected-block queue, checked at every output handshake.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    blk_t         exp_q[$];
    byte unsigned msg[$];
    int           errs = 0;
    int           nchk = 0;
    int           hold = 0;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Byte-stream padding: msg, 0x80, zeros to 56 mod 64, 64-bit length
    task automatic model_push();
        byte unsigned    p[$];
        longint unsigned bl;
        int              nb;
        blk_t            e;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = longint'(msg.size()) * 8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bl >> (8 * k)));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++)
                e.data[511 - 8*j -: 8] = p[64*b + j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_abc();
        blk_t e;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        e.data = '0;
        e.data[511:480] = 32'h61626380;
        e.data[31:0]    = 32'h00000018;
        e.first = 1'b1;
        e.last  = 1'b1;
        exp_q.push_back(e);
    endtask

    // Called and returns on a falling edge
    task automatic send_word(input logic [31:0] d, input logic l,
                             input logic [2:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input int stop_after);
        int          n;
        int          nw;
        int          lb;
        logic [31:0] w;
        logic [2:0]  benc;
        n = msg.size();
        if (n % 4 != 0 || n == 0 || $urandom_range(0, 1) == 1) begin
            nw = n / 4 + 1;
            lb = n % 4;
        end else begin
            nw = n / 4;
            lb = 4;
        end
        benc = (lb == 4) ? 3'($urandom_range(4, 7)) : 3'(lb);
        for (int wi = 0; wi < nw; wi++) begin
            if (wi == stop_after) return;
            for (int k = 0; k < 4; k++)
                w[31 - 8*k -: 8] = (4*wi + k < n) ? msg[4*wi + k]
                                                  : 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            send_word(w, wi == nw - 1, benc);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_blk_first", blk_first, 0);
        chk("rst_blk_last", blk_last, 0);
    endtask

    // Output side: random ready, stability under stall, scoreboard
    initial begin
        logic [511:0] held_d;
        logic [1:0]   held_f;
        bit           held_v;
        blk_t         e;
        held_v    = 1'b0;
        held_d    = '0;
        held_f    = '0;
        blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v    = 1'b0;
                blk_ready = 1'b0;
            end else begin
                chk("in_ready_excl", in_ready, !blk_valid);
                if (held_v) begin
                    chk("stall_valid", blk_valid, 1);
                    chk("stall_data", blk_data, held_d);
                    chk("stall_flags", {blk_first, blk_last}, held_f);
                end
                if (blk_valid && hold > 0) begin
                    blk_ready = 1'b0;
                    hold--;
                end else begin
                    blk_ready = ($urandom_range(0, 3) != 0);
                end
                held_v = blk_valid && !blk_ready;
                held_d = blk_data;
                held_f = {blk_first, blk_last};
                if (blk_valid && blk_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_blk", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", blk_data, e.data);
                        chk("blk_first", blk_first, e.first);
                        chk("blk_last", blk_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        push_abc();
        send_msg(-1);
        rand_msg(0);
        model_push();
        send_msg(-1);
        rand_msg(56);
        model_push();
        send_msg(-1);
        rand_msg(64);
        model_push();
        send_msg(-1);
        wait_idle();

        hold = 10;
        rand_msg(3);
        model_push();
        send_msg(-1);
        wait_idle();

        for (int m = 0; m < 25; m++) begin
            rand_msg($urandom_range(0, 200));
            model_push();
            send_msg(-1);
        end
        wait_idle();

        rand_msg(40);
        send_msg(5);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        push_abc();
        send_msg(-1);
        wait_idle();

        hold = 1000;
        rand_msg(8);
        send_msg(-1);
        guard = 0;
        while (!blk_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("emit_seen", blk_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        hold = 0;
        chk_reset_vals();
        rst = 1'b0;
        push_abc();
        send_msg(-1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
